// File: rtl/sid_bus_sequencer.sv
// sid_bus_sequencer: replays FIFO-buffered host commands as single-cycle SID register writes,
// with tick-timed WAITs. Define SID_SHADOW_EN to add the 32x8 shadow readback array.
module sid_bus_sequencer #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CLKen,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [15:0]        IN_CMD,
  output logic               WR,
  output logic [4:0]         ADDR,
  output logic [7:0]         DATA,
  output logic               BUSY,
  output logic [FIFO_AW:0]   LEVEL,
  input  logic [4:0]         RD_ADDR,
  output logic [7:0]         RD_DATA
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   LvlFull = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LvlOne  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PtrOne  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              r_state, w_state_d;
  logic [15:0]         r_mem [Depth];
  logic [FIFO_AW-1:0]  r_wptr, r_rptr;
  logic [FIFO_AW:0]    r_level, w_level_d;
  logic [12:0]         r_cmd, w_cmd_d;
  logic [14:0]         r_cnt, w_cnt_d;
  logic                r_wr;
  logic [4:0]          r_addr;
  logic [7:0]          r_data;
  logic                w_full, w_empty, w_push, w_pop, w_issue;
  logic [15:0]         w_head;

  assign w_full   = (r_level == LvlFull);
  assign w_empty  = (r_level == '0);
  assign IN_READY = RSTn & ~w_full & ~FLUSH;
  assign w_push   = IN_VALID & IN_READY;
  assign w_head   = r_mem[r_rptr];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= IN_CMD;
  end

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LvlOne;
      2'b01:   w_level_d = r_level - LvlOne;
      default: w_level_d = r_level;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_cmd_d   = r_cmd;
    w_cnt_d   = r_cnt;
    w_pop     = 1'b0;
    w_issue   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_cmd_d = w_head[12:0];
          if (w_head[15]) begin
            w_cnt_d   = w_head[14:0];
            w_state_d = StWait;
          end else begin
            w_state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (CLKen) begin
          w_issue   = 1'b1;
          w_state_d = StIdle;
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_d = StIdle;
        end else if (CLKen) begin
          w_cnt_d = r_cnt - 15'd1;
          if (r_cnt == 15'd1) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Abort wins over everything, including a pending issue on this edge.
    if (FLUSH) begin
      w_state_d = StIdle;
      w_pop     = 1'b0;
      w_issue   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= StIdle;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cmd   <= w_cmd_d;
      r_cnt   <= w_cnt_d;
      r_wr    <= w_issue;
      if (FLUSH) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        r_level <= w_level_d;
        if (w_push) r_wptr <= r_wptr + PtrOne;
        if (w_pop)  r_rptr <= r_rptr + PtrOne;
      end
      if (w_issue) begin
        r_addr <= r_cmd[12:8];
        r_data <= r_cmd[7:0];
      end
    end
  end

  assign WR    = r_wr;
  assign ADDR  = r_addr;
  assign DATA  = r_data;
  assign LEVEL = r_level;
  assign BUSY  = !w_empty || (r_state != StIdle);

`ifdef SID_SHADOW_EN
  logic [7:0] r_shadow [32];
  logic [7:0] r_rd_data;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_issue) r_shadow[r_cmd[12:8]] <= r_cmd[7:0];
      // Forward a same-edge write so the read never returns stale data.
      if (w_issue && (r_cmd[12:8] == RD_ADDR)) r_rd_data <= r_cmd[7:0];
      else                                     r_rd_data <= r_shadow[RD_ADDR];
    end
  end

  assign RD_DATA = r_rd_data;
`else
  logic w_rd_addr_unused;
  assign w_rd_addr_unused = ^RD_ADDR;
  assign RD_DATA = 8'h00;
`endif

endmodule

// File: tb/tb_sid_bus_sequencer.sv
// tb_sid_bus_sequencer: table-driven vectors plus hand sequences, writes checked by a scoreboard.
`timescale 1ns/1ps
module tb_sid_bus_sequencer;

  localparam int unsigned FIFO_AW = 4;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              CLKen = 1'b0;
  logic              FLUSH = 1'b0;
  logic              IN_VALID = 1'b0;
  logic [15:0]       IN_CMD = '0;
  logic [4:0]        RD_ADDR = '0;
  logic              IN_READY, WR, BUSY;
  logic [4:0]        ADDR;
  logic [7:0]        DATA, RD_DATA;
  logic [FIFO_AW:0]  LEVEL;

  typedef struct { logic [4:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] cmd; logic [4:0] addr; logic [7:0] data; } vec_t;

  wr_t  exp_q[$];
  wr_t  obs_q[$];
  int   obs_rd = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   ck_periodic = 1'b0;
  logic ck_level = 1'b0;
  int   ck_div = 0;

`ifdef SID_SHADOW_EN
  localparam logic [7:0] ExpRd = 8'h1F;
`else
  localparam logic [7:0] ExpRd = 8'h00;
`endif

  sid_bus_sequencer #(.FIFO_AW(FIFO_AW)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .CLKen   (CLKen),
    .FLUSH   (FLUSH),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .IN_CMD  (IN_CMD),
    .WR      (WR),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .BUSY    (BUSY),
    .LEVEL   (LEVEL),
    .RD_ADDR (RD_ADDR),
    .RD_DATA (RD_DATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #1;
    if (ck_periodic) begin
      CLKen = (ck_div == 15);
      ck_div = (ck_div + 1) % 16;
    end else begin
      CLKen = ck_level;
    end
  end

  always @(negedge CLK) begin : monitor
    wr_t w;
    if (WR === 1'b1) begin
      w.addr = ADDR;
      w.data = DATA;
      w.cyc  = cyc;
      obs_q.push_back(w);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic push(logic [15:0] cmd, bit expect_wr, logic [4:0] a, logic [7:0] d);
    bit ok = 1'b0;
    wr_t e;
    IN_VALID = 1'b1;
    IN_CMD   = cmd;
    for (int t = 0; t < 500; t++) begin
      #1;
      ok = IN_READY;
      @(posedge CLK);
      #2;
      if (ok) break;
    end
    IN_VALID = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout got=not_accepted want=accepted cmd=%h", cmd);
    end else if (expect_wr) begin
      e.addr = a;
      e.data = d;
      e.cyc  = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(string name, int budget);
    int  t = 0;
    wr_t e, o;
    while ((obs_q.size() - obs_rd) < exp_q.size() && t < budget) begin
      step();
      t++;
    end
    if ((obs_q.size() - obs_rd) < exp_q.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout got=%0d writes want=%0d", name, obs_q.size() - obs_rd,
               exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      check({name, "_addr"}, 32'(o.addr), 32'(e.addr));
      check({name, "_data"}, 32'(o.data), 32'(e.data));
    end
    exp_q.delete();
    step(3);
    check({name, "_extra_wr"}, obs_q.size() - obs_rd, 0);
    obs_rd = obs_q.size();
  endtask

  vec_t vecs[6];
  int   first;

  initial begin
    vecs[0] = '{16'h0A55, 5'h0A, 8'h55};
    vecs[1] = '{16'h1FAA, 5'h1F, 8'hAA};
    vecs[2] = '{16'h1000, 5'h10, 8'h00};
    vecs[3] = '{16'h00FF, 5'h00, 8'hFF};
    vecs[4] = '{16'h15C3, 5'h15, 8'hC3};
    vecs[5] = '{16'h6E3C, 5'h0E, 8'h3C};

    // Reset values.
    ck_level = 1'b1;
    step(2);
    check("rst_wr", 32'(WR), 0);
    check("rst_addr", 32'(ADDR), 0);
    check("rst_data", 32'(DATA), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_rd_data", 32'(RD_DATA), 0);
    check("rst_in_ready", 32'(IN_READY), 0);
    RSTn = 1'b1;
    step(2);
    check("post_rst_in_ready", 32'(IN_READY), 1);

    // Single write latency.
    push(16'h0112, 1'b1, 5'h01, 8'h12);
    check("t1_k_level", 32'(LEVEL), 1);
    check("t1_k_wr", 32'(WR), 0);
    check("t1_k_busy", 32'(BUSY), 1);
    step();
    check("t1_k1_level", 32'(LEVEL), 0);
    check("t1_k1_wr", 32'(WR), 0);
    check("t1_k1_busy", 32'(BUSY), 1);
    step();
    check("t1_k2_wr", 32'(WR), 1);
    check("t1_k2_addr", 32'(ADDR), 32'h01);
    check("t1_k2_data", 32'(DATA), 32'h12);
    check("t1_k2_busy", 32'(BUSY), 0);
    step();
    check("t1_k3_wr", 32'(WR), 0);
    check("t1_k3_addr_hold", 32'(ADDR), 32'h01);
    drain("t1", 20);

    // Back-to-back table writes, CLKen held high.
    first = obs_q.size();
    for (int i = 0; i < 6; i++) push(vecs[i].cmd, 1'b1, vecs[i].addr, vecs[i].data);
    drain("tbl", 100);
    if (obs_q.size() >= first + 6) begin
      for (int i = 0; i < 5; i++)
        check("tbl_spacing", obs_q[first + i + 1].cyc - obs_q[first + i].cyc, 2);
    end

    // Timed WAIT between writes, CLKen every 16 cycles.
    ck_periodic = 1'b1;
    step(2);
    first = obs_q.size();
    push(16'h0004, 1'b1, 5'h00, 8'h04);
    push(16'h8003, 1'b0, 5'h00, 8'h00);
    push(16'h0441, 1'b1, 5'h04, 8'h41);
    drain("t2", 400);
    if (obs_q.size() >= first + 2)
      check("t2_tick_spacing", obs_q[first + 1].cyc - obs_q[first].cyc, 64);

    // FLUSH in the middle of a long WAIT.
    push(16'h8064, 1'b0, 5'h00, 8'h00);
    step(20);
    check("t4_busy_waiting", 32'(BUSY), 1);
    FLUSH    = 1'b1;
    IN_VALID = 1'b1;
    IN_CMD   = 16'h0A5A;
    #1;
    check("t4_ready_flush", 32'(IN_READY), 0);
    step();
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    check("t4_busy", 32'(BUSY), 0);
    check("t4_level", 32'(LEVEL), 0);
    check("t4_wr", 32'(WR), 0);
    check("t4_addr_hold", 32'(ADDR), 32'h04);
    check("t4_data_hold", 32'(DATA), 32'h41);
    drain("t4_flushed", 40);
    push(16'h0A5A, 1'b1, 5'h0A, 8'h5A);
    drain("t4_after", 100);

    // Full FIFO with CLKen stalled: one command sits in ISSUE, 16 fill the FIFO.
    ck_periodic = 1'b0;
    ck_level    = 1'b0;
    step(2);
    for (int i = 0; i < 17; i++)
      push({3'b000, 5'(i), 8'(8'hB0 + i)}, 1'b1, 5'(i), 8'(8'hB0 + i));
    check("t3_level_full", 32'(LEVEL), 16);
    check("t3_ready_full", 32'(IN_READY), 0);
    check("t3_busy", 32'(BUSY), 1);
    IN_VALID = 1'b1;
    IN_CMD   = 16'h1DEE;
    step(5);
    check("t3_level_hold", 32'(LEVEL), 16);
    check("t3_no_wr_stalled", obs_q.size() - obs_rd, 0);
    IN_VALID = 1'b0;
    ck_level = 1'b1;
    drain("t3", 200);

    // Shadow readback.
    RD_ADDR = 5'h18;
    push(16'h181F, 1'b1, 5'h18, 8'h1F);
    drain("t5", 20);
    RD_ADDR = 5'h1E;
    step();
    check("t5_rd_unwritten", 32'(RD_DATA), 0);
    RD_ADDR = 5'h18;
    step();
    check("t5_rd_data", 32'(RD_DATA), 32'(ExpRd));

    // Async reset while a write is parked in ISSUE.
    ck_level = 1'b0;
    step(2);
    push(16'h0377, 1'b0, 5'h00, 8'h00);
    push(16'h0288, 1'b0, 5'h00, 8'h00);
    check("t6_busy_pre", 32'(BUSY), 1);
    check("t6_level_pre", 32'(LEVEL), 1);
    #1;
    RSTn = 1'b0;
    #1;
    check("t6_wr", 32'(WR), 0);
    check("t6_addr", 32'(ADDR), 0);
    check("t6_data", 32'(DATA), 0);
    check("t6_level", 32'(LEVEL), 0);
    check("t6_busy", 32'(BUSY), 0);
    check("t6_ready", 32'(IN_READY), 0);
    check("t6_rd_data", 32'(RD_DATA), 0);
    step(2);
    RSTn = 1'b1;
    ck_level = 1'b1;
    step(10);
    drain("t6_after", 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
